// File: rtl/port_arbiter.sv
// ============================================================================
// Module   : port_arbiter
// Function : 3-way round-robin packet arbiter; grant is held for PktLen flits.
//            Optional per-requester packet counters built only when the
//            ARB_STATS_EN macro is defined (counters read 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module port_arbiter #(
    parameter int DataWidth = 32,
    parameter int PktLen    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [DataWidth-1:0] i_data1,
    input  logic [DataWidth-1:0] i_data2,
    input  logic [DataWidth-1:0] i_data3,
    input  logic                 i_data_valid1,
    input  logic                 i_data_valid2,
    input  logic                 i_data_valid3,
    output logic                 o_data_ready1,
    output logic                 o_data_ready2,
    output logic                 o_data_ready3,
    output logic [DataWidth-1:0] o_data,
    output logic                 o_data_valid,
    input  logic                 i_data_ready,
    output logic [2:0]           o_grant,
    output logic [15:0]          o_pkt_count1,
    output logic [15:0]          o_pkt_count2,
    output logic [15:0]          o_pkt_count3
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(PktLen - 1);

    state_t      state;
    logic [1:0]  ptr;        // last served requester, numbered 1..3
    logic [2:0]  grant;
    logic [7:0]  beat;
    logic [2:0]  winner;
    logic [1:0]  grant_num;
    logic        locked;
    logic        xfer;
    logic        last_xfer;

    assign locked    = (state == LOCKED);
    assign xfer      = o_data_valid & i_data_ready;
    assign last_xfer = xfer && (beat == LAST_BEAT);
    assign grant_num = grant[0] ? 2'd1 : (grant[1] ? 2'd2 : 2'd3);
    assign o_grant   = grant;

    // Round-robin search starts just after the last served requester.
    always_comb begin
        winner = 3'b000;
        case (ptr)
            2'd1: begin
                if      (i_data_valid2) winner = 3'b010;
                else if (i_data_valid3) winner = 3'b100;
                else if (i_data_valid1) winner = 3'b001;
            end
            2'd2: begin
                if      (i_data_valid3) winner = 3'b100;
                else if (i_data_valid1) winner = 3'b001;
                else if (i_data_valid2) winner = 3'b010;
            end
            default: begin
                if      (i_data_valid1) winner = 3'b001;
                else if (i_data_valid2) winner = 3'b010;
                else if (i_data_valid3) winner = 3'b100;
            end
        endcase
    end

    always_comb begin
        o_data       = '0;
        o_data_valid = 1'b0;
        if (locked) begin
            if (grant[0]) begin
                o_data       = i_data1;
                o_data_valid = i_data_valid1;
            end else if (grant[1]) begin
                o_data       = i_data2;
                o_data_valid = i_data_valid2;
            end else if (grant[2]) begin
                o_data       = i_data3;
                o_data_valid = i_data_valid3;
            end
        end
    end

    assign o_data_ready1 = locked & grant[0] & i_data_ready;
    assign o_data_ready2 = locked & grant[1] & i_data_ready;
    assign o_data_ready3 = locked & grant[2] & i_data_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            ptr   <= 2'd3;
            grant <= 3'b000;
            beat  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|winner) begin
                        state <= LOCKED;
                        grant <= winner;
                        beat  <= 8'd0;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        if (beat == LAST_BEAT) begin
                            state <= IDLE;
                            grant <= 3'b000;
                            ptr   <= grant_num;
                            beat  <= 8'd0;
                        end else begin
                            beat <= beat + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] pkt_count1;
    logic [15:0] pkt_count2;
    logic [15:0] pkt_count3;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pkt_count1 <= 16'd0;
            pkt_count2 <= 16'd0;
            pkt_count3 <= 16'd0;
        end else if (last_xfer) begin
            if (grant[0]) pkt_count1 <= pkt_count1 + 16'd1;
            if (grant[1]) pkt_count2 <= pkt_count2 + 16'd1;
            if (grant[2]) pkt_count3 <= pkt_count3 + 16'd1;
        end
    end

    assign o_pkt_count1 = pkt_count1;
    assign o_pkt_count2 = pkt_count2;
    assign o_pkt_count3 = pkt_count3;
`else
    logic unused_last_xfer;
    assign unused_last_xfer = last_xfer;
    assign o_pkt_count1     = 16'd0;
    assign o_pkt_count2     = 16'd0;
    assign o_pkt_count3     = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_port_arbiter.sv
// ============================================================================
// Module   : tb_port_arbiter
// Function : Directed scoreboard bench for port_arbiter (PktLen = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_port_arbiter;

    localparam int PKT = 4;
`ifdef ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] d   [3];
    logic        vld [3];
    logic        en  [3];
    logic        rd1, rd2, rd3;
    logic [31:0] o_data;
    logic        o_valid;
    logic        ready;
    logic [2:0]  o_grant;
    logic [15:0] cnt1, cnt2, cnt3;

    // Stimulus sources and scoreboard of expected flits per requester
    logic [31:0] src_q [3][$];
    logic [31:0] exp_q [3][$];
    int          exp_gnt[$];
    int          exp_cnt [3];

    int checks = 0;
    int errors = 0;

    // Reference state of the arbiter
    bit m_locked;
    bit m_new;
    int m_ptr;
    int m_grant;
    int m_beat;

    port_arbiter #(.DataWidth(32), .PktLen(PKT)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_data1       (d[0]),
        .i_data2       (d[1]),
        .i_data3       (d[2]),
        .i_data_valid1 (vld[0]),
        .i_data_valid2 (vld[1]),
        .i_data_valid3 (vld[2]),
        .o_data_ready1 (rd1),
        .o_data_ready2 (rd2),
        .o_data_ready3 (rd3),
        .o_data        (o_data),
        .o_data_valid  (o_valid),
        .i_data_ready  (ready),
        .o_grant       (o_grant),
        .o_pkt_count1  (cnt1),
        .o_pkt_count2  (cnt2),
        .o_pkt_count3  (cnt3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int n, input logic [31:0] base, input int num);
        for (int k = 0; k < num; k++) begin
            src_q[n].push_back(base + 32'(k));
            exp_q[n].push_back(base + 32'(k));
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_new    = 1'b0;
        m_ptr    = 2;
        m_grant  = 0;
        m_beat   = 0;
        for (int n = 0; n < 3; n++) begin
            exp_cnt[n] = 0;
            src_q[n].delete();
            exp_q[n].delete();
        end
        exp_gnt.delete();
    endtask

    task automatic check_counts();
        chk("pkt_count1", 64'(cnt1), 64'(exp_cnt[0]));
        chk("pkt_count2", 64'(cnt2), 64'(exp_cnt[1]));
        chk("pkt_count3", 64'(cnt3), 64'(exp_cnt[2]));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_grant"}, 64'(o_grant), 64'd0);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_ready"}, 64'({rd3, rd2, rd1}), 64'd0);
        chk({tag, "_data"},  64'(o_data), 64'd0);
    endtask

    task automatic check_cycle();
        logic [2:0]  exp_rdy;
        logic [31:0] exp_d;
        int          g;
        check_counts();
        if (!m_locked) begin
            check_idle_outputs("idle");
            for (int k = 0; k < 3; k++) begin
                if (!m_locked && vld[(m_ptr + 1 + k) % 3]) begin
                    m_grant  = (m_ptr + 1 + k) % 3;
                    m_locked = 1'b1;
                    m_new    = 1'b1;
                    m_beat   = 0;
                end
            end
        end else begin
            g       = m_grant;
            exp_rdy = ready ? (3'b001 << g) : 3'b000;
            chk("grant", 64'(o_grant), 64'(3'b001 << g));
            if (m_new) begin
                if (exp_gnt.size() != 0) chk("grant_order", 64'(g + 1), 64'(exp_gnt.pop_front()));
                m_new = 1'b0;
            end
            chk("out_valid", 64'(o_valid), 64'(vld[g]));
            chk("ready", 64'({rd3, rd2, rd1}), 64'(exp_rdy));
            chk("pass_data", 64'(o_data), 64'(d[g]));
            if (vld[g] && ready) begin
                if (exp_q[g].size() == 0) begin
                    chk("sb_underflow", 64'd0, 64'd1);
                end else begin
                    exp_d = exp_q[g].pop_front();
                    chk("flit", 64'(o_data), 64'(exp_d));
                end
                if (src_q[g].size() != 0) void'(src_q[g].pop_front());
                m_beat++;
                if (m_beat == PKT) begin
                    m_locked = 1'b0;
                    m_ptr    = g;
                    if (STATS) exp_cnt[g]++;
                end
            end
        end
    endtask

    // One clock: drive from sources, sample at negedge, return at posedge+1
    task automatic tick();
        for (int n = 0; n < 3; n++) begin
            vld[n] = en[n] && (src_q[n].size() != 0);
            d[n]   = vld[n] ? src_q[n][0] : 32'h0;
        end
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit all_done();
        return !m_locked && src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0;
    endfunction

    task automatic drain(input string tag, input int max);
        int i;
        for (i = 0; i < max; i++) begin
            if (all_done()) break;
            tick();
        end
        chk({tag, "_drain"}, 64'(i < max), 64'd1);
    endtask

    initial begin
        for (int n = 0; n < 3; n++) begin
            d[n]   = 32'h0;
            vld[n] = 1'b0;
            en[n]  = 1'b1;
        end
        ready = 1'b1;
        rst_n = 1'b0;
        model_reset();

        // Reset state
        #12;
        check_idle_outputs("reset");
        check_counts();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick();

        // All three requesters busy: order 1,2,3,1
        load(0, 32'h0100_0000, 8);
        load(1, 32'h0200_0000, 4);
        load(2, 32'h0300_0000, 4);
        exp_gnt.push_back(1); exp_gnt.push_back(2);
        exp_gnt.push_back(3); exp_gnt.push_back(1);
        drain("rr", 60);
        chk("rr_order_used", 64'(exp_gnt.size()), 64'd0);

        // Lone requester 3
        load(2, 32'h0300_0001, 4);
        exp_gnt.push_back(3);
        drain("solo3", 20);

        // Requester 2 with toggling downstream ready, others arriving mid-packet
        load(1, 32'h2200_0000, 4);
        exp_gnt.push_back(2); exp_gnt.push_back(3); exp_gnt.push_back(1);
        tick();
        load(0, 32'h1100_0000, 4);
        load(2, 32'h3300_0000, 4);
        for (int i = 0; i < 80 && !all_done(); i++) begin
            tick();
            ready = ~ready;
        end
        ready = 1'b1;
        chk("toggle_done", 64'(all_done()), 64'd1);

        // Granted requester drops valid mid-packet
        load(1, 32'h2A00_0000, 4);
        exp_gnt.push_back(2); exp_gnt.push_back(3); exp_gnt.push_back(1);
        tick(); tick(); tick();
        en[1] = 1'b0;
        load(2, 32'h3A00_0000, 4);
        load(0, 32'h1A00_0000, 4);
        tick(); tick(); tick();
        en[1] = 1'b1;
        drain("drop", 60);

        // Reset after two of four flits
        load(1, 32'h2B00_0000, 4);
        exp_gnt.push_back(2);
        for (int i = 0; i < 10 && !(m_locked && m_beat == 2); i++) tick();
        chk("mid_pkt_reached", 64'(m_locked && m_beat == 2), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_idle_outputs("async_rst");
        check_counts();
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        tick();
        load(0, 32'h1C00_0000, 4);
        load(1, 32'h2C00_0000, 4);
        exp_gnt.push_back(1); exp_gnt.push_back(2);
        drain("post_rst", 30);
        tick();

        for (int n = 0; n < 3; n++) chk("sb_empty", 64'(exp_q[n].size()), 64'd0);
        chk("order_empty", 64'(exp_gnt.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
